ntt_addr_gen_par: RTL and testbench
===================================

NTT_ADDR_GEN_PAR -- requirements
Module: ntt_addr_gen_par

Interface
REQ-001 SHALL have parameter LOG_N, default 8, meaning log2 of polynomial length N.
REQ-002 SHALL have parameter LOG_BU, default 3, meaning log2 of butterfly lanes and banks NUM_BU; legal only if LOG_BU <= LOG_N-1.
REQ-003 SHALL have parameter MIN_LEN_LOG, default 1, meaning log2 of the smallest butterfly span; STAGES = LOG_N-MIN_LEN_LOG.
REQ-004 SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles inserted between stages (0 legal).
REQ-005 SHALL derive ADW = LOG_N-LOG_BU (bank depth bits) and ZW = LOG_N-1 (zeta address bits).
REQ-006 clk_i  in  1  sole clock, rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 start_i  in  1  begin a transform; sampled only in IDLE.
REQ-009 is_ntt_i  in  1  1=forward NTT, 0=inverse; latched on accepted start.
REQ-010 out_ready_i  in  1  consumer accepts the current beat.
REQ-011 valid_o  out  1  beat on lane outputs is valid.
REQ-012 bank_a_o / bank_b_o  out  NUM_BU*LOG_BU each  per-lane bank index, port A (lower) / port B (upper) coefficient.
REQ-013 addr_a_o / addr_b_o  out  NUM_BU*ADW each  per-lane bank-local address, port A / port B.
REQ-014 zeta_o  out  NUM_BU*ZW  per-lane twiddle ROM address.
REQ-015 olen_o  out  LOG_N  current butterfly span len; stage_o  out  clog2(STAGES)  current stage.
REQ-016 last_o  out  1  final beat of the transform; busy_o  out  1  not IDLE; done_o  out  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM IDLE, RUN, GAP; IDLE->RUN on start_i; RUN->GAP (or RUN, stage+1, if GAP_CYCLES=0) when a stage's last beat is accepted and the stage is not final; GAP->RUN after exactly GAP_CYCLES cycles; RUN->IDLE when the final beat is accepted.
REQ-018 Stage s: len = N>>(s+1) for NTT, len = (1<<MIN_LEN_LOG)<<s for INTT.
REQ-019 Each stage SHALL issue BEATS = N/(2*NUM_BU) beats; beat c, lane i processes butterfly j = c*NUM_BU+i.
REQ-020 Per lane: group = j/len; lo = group*2*len + j%len; hi = lo+len; bank = address[LOG_N-1:ADW]; local = address[ADW-1:0].
REQ-021 Zeta: G = N/(2*len); NTT zeta = G+group; INTT zeta = 2G-1-group; truncated to ZW bits.
REQ-022 All lane outputs, olen_o, stage_o and last_o SHALL be registered; first valid_o rises in the cycle after start_i is sampled.
REQ-023 Beat accepted when valid_o & out_ready_i; while valid_o & !out_ready_i all outputs SHALL hold stable.
REQ-024 valid_o SHALL be 0 in IDLE and GAP; RUN beats SHALL be back-to-back with out_ready_i held 1.
REQ-025 last_o SHALL be 1 only with the final beat of stage STAGES-1.
REQ-026 done_o SHALL pulse exactly one cycle, in the cycle after the final beat is accepted; busy_o falls in that same cycle.
REQ-027 start_i while busy_o=1 SHALL be ignored; start_i coincident with done_o SHALL be ignored.
REQ-028 Total accepted beats per transform SHALL equal STAGES*BEATS.

Reset
REQ-029 rst_i asserted, including mid-transform, SHALL immediately force IDLE and all outputs, counters and latched mode to 0; after release the block SHALL wait for a fresh start_i and SHALL NOT emit done_o for the aborted transform.

Verification (defaults: N=256, NUM_BU=8, STAGES=7, BEATS=16)
REQ-030 NTT start, ready=1 -> beat 0: lo lanes 0..7, bank_a 0, addr_a 0..7, bank_b 4, addr_b 0..7, zeta 1, olen 128; stage 1 beat 0 after exactly 4 invalid cycles with olen 64, zeta 2.
REQ-031 INTT start -> beat 0: lo 0,1,4,5,8,9,12,13; hi = lo+2; zeta 127,127,126,126,125,125,124,124; olen 2; final stage olen 128, zeta 1.
REQ-032 Full NTT, ready=1 -> 112 accepted beats, last_o on beat 112 only, done_o one cycle later, total 112+6*4 cycles from first valid to done.
REQ-033 out_ready_i random 50% -> outputs stable during every stall; beat sequence identical to REQ-032 reference model.
REQ-034 rst_i pulsed at stage 3 beat 5, then new INTT start -> all outputs 0 during reset, no done_o, INTT sequence correct from beat 0.
REQ-035 start_i pulsed mid-run and in done_o cycle -> ignored; parameter sweep LOG_BU=2, GAP_CYCLES=0 -> BEATS=32, no gap cycles, model match.

Source files
------------

// File: rtl/ntt_addr_gen_par_if.sv
// Beat bus between the parallel NTT address generator and its consumer.
// master = generator side, slave = consumer side.
interface ntt_addr_gen_par_if #(
  parameter int LOG_N       = 8,
  parameter int LOG_BU      = 3,
  parameter int MIN_LEN_LOG = 1
);
  localparam int NUM_BU = 1 << LOG_BU;
  localparam int ADW    = LOG_N - LOG_BU;
  localparam int ZW     = LOG_N - 1;
  localparam int STAGES = LOG_N - MIN_LEN_LOG;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                     start_i;
  logic                     is_ntt_i;
  logic                     out_ready_i;
  logic                     valid_o;
  logic [NUM_BU*LOG_BU-1:0] bank_a_o;
  logic [NUM_BU*LOG_BU-1:0] bank_b_o;
  logic [NUM_BU*ADW-1:0]    addr_a_o;
  logic [NUM_BU*ADW-1:0]    addr_b_o;
  logic [NUM_BU*ZW-1:0]     zeta_o;
  logic [LOG_N-1:0]         olen_o;
  logic [SW-1:0]            stage_o;
  logic                     last_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    input  start_i, is_ntt_i, out_ready_i,
    output valid_o, bank_a_o, bank_b_o, addr_a_o, addr_b_o, zeta_o,
           olen_o, stage_o, last_o, busy_o, done_o
  );

  modport slave (
    output start_i, is_ntt_i, out_ready_i,
    input  valid_o, bank_a_o, bank_b_o, addr_a_o, addr_b_o, zeta_o,
           olen_o, stage_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/ntt_addr_gen_par.sv
// Parallel NTT/INTT butterfly address + twiddle generator, all beat outputs registered;
// first beat one cycle after start, beats held stable while out_ready_i is low.
module ntt_addr_gen_par #(
  parameter int LOG_N       = 8,
  parameter int LOG_BU      = 3,
  parameter int MIN_LEN_LOG = 1,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ntt_addr_gen_par_if.master  bus
);
  localparam int NUM_BU = 1 << LOG_BU;
  localparam int ADW    = LOG_N - LOG_BU;
  localparam int ZW     = LOG_N - 1;
  localparam int STAGES = LOG_N - MIN_LEN_LOG;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int BEATS  = 1 << (LOG_N - 1 - LOG_BU);
  localparam int BW     = (LOG_N - 1 - LOG_BU > 0) ? (LOG_N - 1 - LOG_BU) : 1;
  localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;

  state_e                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;
  logic [NUM_BU*LOG_BU-1:0] bank_a_q, bank_a_d, bank_b_q, bank_b_d;
  logic [NUM_BU*ADW-1:0]    addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [NUM_BU*ZW-1:0]     zeta_q, zeta_d;
  logic [LOG_N-1:0]         olen_q, olen_d;
  logic [SW-1:0]            stage_out_q, stage_out_d;

  logic        accept, beat_end, stage_end, run_d;
  logic [31:0] ll, j, grp;
  logic [LOG_N-1:0] len_v, lo, hi;
  logic [ZW-1:0]    z;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    stage_d   = stage_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    accept    = valid_q & bus.out_ready_i;
    beat_end  = (beat_q == BW'(BEATS - 1));
    stage_end = (stage_q == SW'(STAGES - 1));
    case (state_q)
      // A start landing in the done cycle is dropped on purpose.
      IDLE: if (bus.start_i && !done_q) begin
        state_d = RUN;
        mode_d  = bus.is_ntt_i;
        stage_d = '0;
        beat_d  = '0;
      end
      RUN: if (accept) begin
        if (!beat_end) begin
          beat_d = beat_q + 1'b1;
        end else if (stage_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          stage_d = '0;
          beat_d  = '0;
        end else begin
          stage_d = stage_q + 1'b1;
          beat_d  = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? RUN : GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane values are built from the next beat so they land in flops with valid_o.
  always_comb begin
    run_d       = (state_d == RUN);
    valid_d     = run_d;
    last_d      = run_d && (stage_d == SW'(STAGES - 1)) && (beat_d == BW'(BEATS - 1));
    stage_out_d = run_d ? stage_d : '0;
    bank_a_d    = '0;
    bank_b_d    = '0;
    addr_a_d    = '0;
    addr_b_d    = '0;
    zeta_d      = '0;
    olen_d      = '0;
    ll          = '0;
    j           = '0;
    grp         = '0;
    len_v       = '0;
    lo          = '0;
    hi          = '0;
    z           = '0;
    if (run_d) begin
      ll     = mode_d ? (32'(LOG_N - 1) - 32'(stage_d)) : (32'(MIN_LEN_LOG) + 32'(stage_d));
      len_v  = LOG_N'(32'd1 << ll);
      olen_d = len_v;
      for (int i = 0; i < NUM_BU; i++) begin
        j   = 32'(beat_d) * 32'(NUM_BU) + 32'(i);
        grp = j >> ll;
        lo  = LOG_N'((grp << (ll + 32'd1)) | (j & ((32'd1 << ll) - 32'd1)));
        hi  = lo + len_v;
        z   = mode_d ? ZW'((32'd1 << (32'(LOG_N - 1) - ll)) + grp)
                     : ZW'((32'd2 << (32'(LOG_N - 1) - ll)) - 32'd1 - grp);
        bank_a_d[i*LOG_BU +: LOG_BU] = lo[LOG_N-1 -: LOG_BU];
        bank_b_d[i*LOG_BU +: LOG_BU] = hi[LOG_N-1 -: LOG_BU];
        addr_a_d[i*ADW +: ADW]       = lo[ADW-1:0];
        addr_b_d[i*ADW +: ADW]       = hi[ADW-1:0];
        zeta_d[i*ZW +: ZW]           = z;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      stage_q     <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      bank_a_q    <= '0;
      bank_b_q    <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      zeta_q      <= '0;
      olen_q      <= '0;
      stage_out_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stage_q     <= stage_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      bank_a_q    <= bank_a_d;
      bank_b_q    <= bank_b_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      zeta_q      <= zeta_d;
      olen_q      <= olen_d;
      stage_out_q <= stage_out_d;
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.bank_a_o = bank_a_q;
  assign bus.bank_b_o = bank_b_q;
  assign bus.addr_a_o = addr_a_q;
  assign bus.addr_b_o = addr_b_q;
  assign bus.zeta_o   = zeta_q;
  assign bus.olen_o   = olen_q;
  assign bus.stage_o  = stage_out_q;
  assign bus.last_o   = last_q;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
endmodule

// File: tb/tb_ntt_addr_gen_par.sv
// Bench for ntt_addr_gen_par: default instance plus a LOG_BU=2 / GAP_CYCLES=0 instance,
// both checked beat by beat against a butterfly-list model built from plain arithmetic.
module tb_ntt_addr_gen_par;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_addr_gen_par_if #(.LOG_N(8), .LOG_BU(3), .MIN_LEN_LOG(1)) if0();
  ntt_addr_gen_par_if #(.LOG_N(8), .LOG_BU(2), .MIN_LEN_LOG(1)) if1();

  ntt_addr_gen_par #(.LOG_N(8), .LOG_BU(3), .MIN_LEN_LOG(1), .GAP_CYCLES(4))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  ntt_addr_gen_par #(.LOG_N(8), .LOG_BU(2), .MIN_LEN_LOG(1), .GAP_CYCLES(0))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  typedef struct {
    logic [63:0] ba, bb, aa, ab, z;
    logic [7:0]  olen;
    logic [2:0]  stg;
    logic        vld, last, busy, done;
  } obs_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] lit_ba, lit_bb, lit_aa, lit_ab, lit_z;
  logic [6:0]  lit_z0 [0:6];
  logic [7:0]  lit_olen [0:6];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.ba = 64'(if0.bank_a_o); o.bb = 64'(if0.bank_b_o);
      o.aa = 64'(if0.addr_a_o); o.ab = 64'(if0.addr_b_o);
      o.z  = 64'(if0.zeta_o);   o.olen = if0.olen_o; o.stg = if0.stage_o;
      o.vld = if0.valid_o; o.last = if0.last_o; o.busy = if0.busy_o; o.done = if0.done_o;
    end else begin
      o.ba = 64'(if1.bank_a_o); o.bb = 64'(if1.bank_b_o);
      o.aa = 64'(if1.addr_a_o); o.ab = 64'(if1.addr_b_o);
      o.z  = 64'(if1.zeta_o);   o.olen = if1.olen_o; o.stg = if1.stage_o;
      o.vld = if1.valid_o; o.last = if1.last_o; o.busy = if1.busy_o; o.done = if1.done_o;
    end
    return o;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic ntt, input logic rdy);
    if (sel == 0) begin
      if0.start_i = st; if0.is_ntt_i = ntt; if0.out_ready_i = rdy;
    end else begin
      if1.start_i = st; if1.is_ntt_i = ntt; if1.out_ready_i = rdy;
    end
  endtask

  // Expected lane vectors for stage s, beat c, straight from the butterfly definition.
  task automatic model_beat(input int lbu, input bit ntt, input int s, input int c,
                            output logic [63:0] ba, bb, aa, ab, z, output int olen);
    int nbu, adw, len, jj, grp, lo, hi, g, zt;
    nbu = 2 ** lbu;
    adw = 8 - lbu;
    len = ntt ? (256 / (2 ** (s + 1))) : (2 * (2 ** s));
    g   = 256 / (2 * len);
    ba = '0; bb = '0; aa = '0; ab = '0; z = '0;
    for (int i = 0; i < nbu; i++) begin
      jj  = c * nbu + i;
      grp = jj / len;
      lo  = grp * 2 * len + jj % len;
      hi  = lo + len;
      zt  = ntt ? (g + grp) : (2 * g - 1 - grp);
      ba |= 64'(lo / (2 ** adw)) << (i * lbu);
      bb |= 64'(hi / (2 ** adw)) << (i * lbu);
      aa |= 64'(lo % (2 ** adw)) << (i * adw);
      ab |= 64'(hi % (2 ** adw)) << (i * adw);
      z  |= 64'(zt % 128) << (i * 7);
    end
    olen = len;
  endtask

  task automatic run_xform(input int sel, input bit ntt, input bit rnd,
                           input int ab_s, input int ab_c, input bit poke);
    int lbu, gapc, beats, s, c, acc, cyc, gap_cnt, eol;
    bit rdy, prev_stall, in_gap, fin, fin_pend;
    obs_t o, prev;
    logic [63:0] eba, ebb, eaa, eab, ez;
    lbu = (sel == 0) ? 3 : 2;
    gapc = (sel == 0) ? 4 : 0;
    beats = 128 / (2 ** lbu);
    s = 0; c = 0; acc = 0; cyc = 0; gap_cnt = 0;
    prev_stall = 0; in_gap = 0; fin = 0; fin_pend = 0;
    @(negedge clk); set_in(sel, 1'b1, ntt, 1'b0);
    @(negedge clk); set_in(sel, 1'b0, ntt, 1'b0);
    while (!fin && cyc < 4000) begin
      o = get_obs(sel);
      if (cyc == 0) check_eq("first_valid", 64'(o.vld), 64'd1);
      if (ab_s >= 0 && s == ab_s && c == ab_c && o.vld) begin
        rst = 1'b1;
        #1;
        o = get_obs(sel);
        check_eq("rst_flags", {61'd0, o.vld, o.busy, o.done}, 64'd0);
        check_eq("rst_lanes", o.ba | o.bb | o.aa | o.ab | o.z, 64'd0);
        check_eq("rst_misc", {52'd0, o.olen, o.stg, o.last}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_in(sel, 1'b0, ntt, 1'b1);
        repeat (10) begin
          @(negedge clk);
          o = get_obs(sel);
          check_eq("post_abort", {61'd0, o.vld, o.busy, o.done}, 64'd0);
        end
        return;
      end
      if (o.vld) begin
        if (in_gap) begin
          check_eq("gap_len", 64'(gap_cnt), 64'(gapc));
          in_gap = 0;
        end
        model_beat(lbu, ntt, s, c, eba, ebb, eaa, eab, ez, eol);
        check_eq("bank_a", o.ba, eba);
        check_eq("bank_b", o.bb, ebb);
        check_eq("addr_a", o.aa, eaa);
        check_eq("addr_b", o.ab, eab);
        check_eq("zeta", o.z, ez);
        check_eq("olen", 64'(o.olen), 64'(eol));
        check_eq("stage", 64'(o.stg), 64'(s));
        check_eq("last", 64'(o.last), 64'(s == 6 && c == beats - 1));
        if (prev_stall) begin
          check_eq("stall_hold_addr", o.aa, prev.aa);
          check_eq("stall_hold_zeta", o.z, prev.z);
        end
        if (sel == 0 && c == 0) begin
          lit_z0[s] = o.z[6:0];
          lit_olen[s] = o.olen;
          if (s == 0) begin
            lit_ba = o.ba; lit_bb = o.bb; lit_aa = o.aa; lit_ab = o.ab; lit_z = o.z;
          end
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy) begin
          acc++;
          prev_stall = 0;
          if (c == beats - 1) begin
            c = 0;
            if (s == 6) fin_pend = 1;
            else begin s++; in_gap = 1; gap_cnt = 0; end
          end else begin
            c++;
          end
        end else begin
          prev_stall = 1;
          prev = o;
        end
      end else begin
        if (in_gap) begin
          gap_cnt++;
          check_eq("gap_busy", 64'(o.busy), 64'd1);
        end else begin
          check_eq("vld_in_run", 64'(o.vld), 64'd1);
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (poke && cyc == 37) set_in(sel, 1'b1, !ntt, rdy);
      else set_in(sel, 1'b0, ntt, rdy);
      @(negedge clk);
      cyc++;
      if (fin_pend) begin
        o = get_obs(sel);
        check_eq("done_pulse", {61'd0, o.done, o.busy, o.vld}, 64'b100);
        check_eq("beat_total", 64'(acc), 64'(7 * beats));
        if (!rnd) check_eq("latency", 64'(cyc), 64'(7 * beats + 6 * gapc));
        set_in(sel, poke, ntt, 1'b1);
        @(negedge clk);
        set_in(sel, 1'b0, ntt, 1'b1);
        o = get_obs(sel);
        check_eq("done_clear", {61'd0, o.done, o.busy, o.vld}, 64'd0);
        fin = 1;
      end
    end
    if (!fin) check_eq("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] e_aa, e_bb, e_ilo, e_ihi, e_iz;
    obs_t o;
    int ilo [0:7];
    int iz  [0:7];
    set_in(0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o = get_obs(k);
      check_eq("reset_flags", {61'd0, o.vld, o.busy, o.done}, 64'd0);
      check_eq("reset_lanes", o.ba | o.bb | o.aa | o.ab | o.z, 64'd0);
      check_eq("reset_misc", {52'd0, o.olen, o.stg, o.last}, 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_xform(0, 1'b1, 1'b0, -1, 0, 1'b1);
    e_aa = '0; e_bb = '0;
    for (int i = 0; i < 8; i++) begin
      e_aa |= 64'(i) << (i * 5);
      e_bb |= 64'd4 << (i * 3);
    end
    check_eq("ntt_b0_bank_a", lit_ba, 64'd0);
    check_eq("ntt_b0_addr_a", lit_aa, e_aa);
    check_eq("ntt_b0_bank_b", lit_bb, e_bb);
    check_eq("ntt_b0_addr_b", lit_ab, e_aa);
    check_eq("ntt_b0_zeta0", 64'(lit_z0[0]), 64'd1);
    check_eq("ntt_b0_olen", 64'(lit_olen[0]), 64'd128);
    check_eq("ntt_s1_olen", 64'(lit_olen[1]), 64'd64);
    check_eq("ntt_s1_zeta0", 64'(lit_z0[1]), 64'd2);

    run_xform(0, 1'b1, 1'b1, -1, 0, 1'b0);
    run_xform(0, 1'b0, 1'b0, 3, 5, 1'b0);

    run_xform(0, 1'b0, 1'b0, -1, 0, 1'b1);
    ilo = '{0, 1, 4, 5, 8, 9, 12, 13};
    iz  = '{127, 127, 126, 126, 125, 125, 124, 124};
    e_ilo = '0; e_ihi = '0; e_iz = '0;
    for (int i = 0; i < 8; i++) begin
      e_ilo |= 64'(ilo[i]) << (i * 5);
      e_ihi |= 64'(ilo[i] + 2) << (i * 5);
      e_iz  |= 64'(iz[i]) << (i * 7);
    end
    check_eq("intt_b0_addr_a", lit_aa, e_ilo);
    check_eq("intt_b0_addr_b", lit_ab, e_ihi);
    check_eq("intt_b0_zeta", lit_z, e_iz);
    check_eq("intt_b0_olen", 64'(lit_olen[0]), 64'd2);
    check_eq("intt_s6_olen", 64'(lit_olen[6]), 64'd128);
    check_eq("intt_s6_zeta0", 64'(lit_z0[6]), 64'd1);

    run_xform(1, 1'b1, 1'b0, -1, 0, 1'b0);
    run_xform(1, 1'b0, 1'b1, -1, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
